game_aux_io: RTL and testbench

- Support block for the rock-paper-scissors game top level. Contains three functions in one module:
  - a clock divider producing the slow display-scan clock;
  - a bank of key debouncers that turn raw push-button levels into single-cycle press pulses;
  - a melody tone generator driving the speaker.
- All logic runs on the single system clock. There are no generated clocks inside the block; clk_div is an output only.

---
 rtl/game_aux_io_if.sv | 29 ++
 rtl/game_aux_io.sv | 140 ++++++++++++++
 tb/tb_game_aux_io.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_aux_io_if.sv
// Pin bundle for the rock-paper-scissors auxiliary I/O block.
// It carries the key inputs and pulses, the display-scan clock, the melody enable and the speaker output.
interface game_aux_io_if #(
   parameter int N_KEYS = 8
);
   logic [N_KEYS-1:0] key_i;
   logic [N_KEYS-1:0] key_o;
   logic              clk_div;
   logic              beep_en;
   logic              speaker;

   // Game top level side: it drives the raw keys and the melody enable.
   modport master (
      output key_i,
      output beep_en,
      input  key_o,
      input  clk_div,
      input  speaker
   );

   // Auxiliary block side.
   modport slave (
      input  key_i,
      input  beep_en,
      output key_o,
      output clk_div,
      output speaker
   );
endinterface

// File: rtl/game_aux_io.sv
// Auxiliary I/O for the rock-paper-scissors game.
// It contains a display-scan clock divider, a bank of key debouncers that emit press pulses,
// and a looping eight-note melody generator for the speaker.
// The whole block runs on one system clock. clk_div is only a registered output.
module game_aux_io #(
   parameter int DIV_NUM     = 1000,
   parameter int N_KEYS      = 8,
   parameter int DB_CYCLES   = 20000,
   parameter int NOTE_CYCLES = 250000,
   parameter int TONE_SHIFT  = 0
) (
   input  logic          clk,
   input  logic          rst,
   game_aux_io_if.slave  io
);

   localparam int DIV_HALF = DIV_NUM / 2;
   localparam int DIV_W    = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
   localparam int DB_W     = $clog2(DB_CYCLES);
   localparam int NOTE_W   = $clog2(NOTE_CYCLES);

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV_HALF - 1);
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
   localparam logic [NOTE_W-1:0] NOTE_LAST = NOTE_W'(NOTE_CYCLES - 1);

   // Half-period table at 1 MHz, scaled by TONE_SHIFT and never allowed to reach zero.
   function automatic logic [10:0] tone_half(input logic [2:0] idx);
      logic [10:0] base;
      logic [10:0] shifted;
      case (idx)
         3'd0:    base = 11'd1911;  // C4
         3'd1:    base = 11'd1703;  // D4
         3'd2:    base = 11'd1517;  // E4
         3'd3:    base = 11'd1432;  // F4
         3'd4:    base = 11'd1276;  // G4
         3'd5:    base = 11'd1136;  // A4
         3'd6:    base = 11'd1012;  // B4
         3'd7:    base = 11'd956;   // C5
         default: base = 11'd1911;
      endcase
      shifted = base >> TONE_SHIFT;
      if (shifted == 11'd0) begin
         return 11'd1;
      end else begin
         return shifted;
      end
   endfunction

   logic [DIV_W-1:0]  div_cnt_r;
   logic              clk_div_r;
   logic [N_KEYS-1:0] sync1_r;
   logic [N_KEYS-1:0] sync2_r;
   logic [N_KEYS-1:0] deb_r;
   logic [DB_W-1:0]   db_cnt_r [N_KEYS];
   logic [N_KEYS-1:0] key_o_r;
   logic [NOTE_W-1:0] dur_cnt_r;
   logic [10:0]       tone_cnt_r;
   logic [2:0]        note_idx_r;
   logic              speaker_r;
   logic [10:0]       half_s;

   // Display-scan divider: the output toggles every DIV_NUM/2 clocks.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt_r <= '0;
         clk_div_r <= 1'b0;
      end else if (div_cnt_r == DIV_LAST) begin
         div_cnt_r <= '0;
         clk_div_r <= ~clk_div_r;
      end else begin
         div_cnt_r <= div_cnt_r + DIV_W'(1);
      end
   end

   // Key debouncers: synchronize each key, accept a level change after DB_CYCLES stable clocks,
   // and pulse only on an accepted press.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_r <= '0;
         sync2_r <= '0;
         deb_r   <= '0;
         key_o_r <= '0;
         for (int i = 0; i < N_KEYS; i++) begin
            db_cnt_r[i] <= '0;
         end
      end else begin
         sync1_r <= io.key_i;
         sync2_r <= sync1_r;
         for (int i = 0; i < N_KEYS; i++) begin
            key_o_r[i] <= sync2_r[i] & ~deb_r[i] & (db_cnt_r[i] == DB_LAST);
            if (sync2_r[i] == deb_r[i]) begin
               db_cnt_r[i] <= '0;
            end else if (db_cnt_r[i] == DB_LAST) begin
               deb_r[i]    <= sync2_r[i];
               db_cnt_r[i] <= '0;
            end else begin
               db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
            end
         end
      end
   end

   // Effective half-period of the note that is currently playing.
   always_comb begin
      half_s = tone_half(note_idx_r);
   end

   // Melody sequencer: it steps through the notes every NOTE_CYCLES and squares the speaker at each note's half-period.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dur_cnt_r  <= '0;
         tone_cnt_r <= 11'd0;
         note_idx_r <= 3'd0;
         speaker_r  <= 1'b0;
      end else if (!io.beep_en) begin
         dur_cnt_r  <= '0;
         tone_cnt_r <= 11'd0;
         note_idx_r <= 3'd0;
         speaker_r  <= 1'b0;
      end else if (dur_cnt_r == NOTE_LAST) begin
         dur_cnt_r  <= '0;
         tone_cnt_r <= 11'd0;
         note_idx_r <= note_idx_r + 3'd1;
         speaker_r  <= 1'b0;
      end else begin
         dur_cnt_r <= dur_cnt_r + NOTE_W'(1);
         if (tone_cnt_r == (half_s - 11'd1)) begin
            tone_cnt_r <= 11'd0;
            speaker_r  <= ~speaker_r;
         end else begin
            tone_cnt_r <= tone_cnt_r + 11'd1;
         end
      end
   end

   assign io.key_o   = key_o_r;
   assign io.clk_div = clk_div_r;
   assign io.speaker = speaker_r;

endmodule

// File: tb/tb_game_aux_io.sv
// Scoreboard bench for game_aux_io.
// The stimulus pushes the expected output events, each as a cycle number and a value.
// A negedge monitor pops one entry whenever a key pulse, a clk_div change or a speaker change appears.
module tb_game_aux_io;

   typedef struct {
      int         cyc;
      logic [7:0] val;
   } ev_t;

   logic clk;
   logic rst;
   int   cyc;
   int   checks;
   int   errors;

   ev_t key_q[$];
   ev_t div_q[$];
   ev_t spk_q[$];

   game_aux_io_if #(.N_KEYS(8)) io();

   game_aux_io #(
      .DIV_NUM     (10),
      .N_KEYS      (8),
      .DB_CYCLES   (4),
      .NOTE_CYCLES (64),
      .TONE_SHIFT  (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .io  (io)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Edge count since the last reset release: the value is k after clk edge k.
   always @(posedge clk or negedge rst) begin
      if (!rst) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cmp(input string name, input bit have, input ev_t e, input int now, input logic [7:0] act);
      checks++;
      if (!have) begin
         errors++;
         $display("FAIL %s: unexpected event at cycle %0d value %0h", name, now, act);
      end else if (e.cyc != now || e.val !== act) begin
         errors++;
         $display("FAIL %s: got cycle %0d value %0h, expected cycle %0d value %0h", name, now, act, e.cyc, e.val);
      end
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_edges(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic push(input int which, input int c, input logic [7:0] v);
      ev_t e;
      e.cyc = c;
      e.val = v;
      if (which == 0) key_q.push_back(e);
      else if (which == 1) div_q.push_back(e);
      else spk_q.push_back(e);
   endtask

   task automatic push_div(input int n);
      for (int k = 1; k <= n; k++) push(1, 5 * k, (k % 2 == 1) ? 8'h01 : 8'h00);
   endtask

   // Empty every queue. An entry due at or before 'limit' is an event the DUT never produced.
   task automatic drain(input int limit);
      int missed;
      ev_t e;
      missed = 0;
      while (key_q.size() > 0) begin e = key_q.pop_front(); if (e.cyc <= limit) missed++; end
      checks++;
      if (missed != 0) begin errors++; $display("FAIL key_missed: %0d events missing, expected 0", missed); end
      missed = 0;
      while (div_q.size() > 0) begin e = div_q.pop_front(); if (e.cyc <= limit) missed++; end
      checks++;
      if (missed != 0) begin errors++; $display("FAIL div_missed: %0d events missing, expected 0", missed); end
      missed = 0;
      while (spk_q.size() > 0) begin e = spk_q.pop_front(); if (e.cyc <= limit) missed++; end
      checks++;
      if (missed != 0) begin errors++; $display("FAIL spk_missed: %0d events missing, expected 0", missed); end
   endtask

   // Monitor: pop and compare one entry on every output event.
   initial begin
      logic pdiv;
      logic pspk;
      ev_t  e;
      pdiv = 1'b0;
      pspk = 1'b0;
      forever begin
         @(negedge clk);
         if (rst !== 1'b1) begin
            pdiv = io.clk_div;
            pspk = io.speaker;
         end else begin
            if (io.key_o !== 8'h00) begin
               if (key_q.size() > 0) begin e = key_q.pop_front(); cmp("key_o", 1'b1, e, cyc, io.key_o); end
               else cmp("key_o", 1'b0, e, cyc, io.key_o);
            end
            if (io.clk_div !== pdiv) begin
               if (div_q.size() > 0) begin e = div_q.pop_front(); cmp("clk_div", 1'b1, e, cyc, {7'd0, io.clk_div}); end
               else cmp("clk_div", 1'b0, e, cyc, {7'd0, io.clk_div});
               pdiv = io.clk_div;
            end
            if (io.speaker !== pspk) begin
               if (spk_q.size() > 0) begin e = spk_q.pop_front(); cmp("speaker", 1'b1, e, cyc, {7'd0, io.speaker}); end
               else cmp("speaker", 1'b0, e, cyc, {7'd0, io.speaker});
               pspk = io.speaker;
            end
         end
      end
   end

   // Stimulus with hand-derived expected events.
   initial begin
      int c;
      int t0;
      int t1;
      int r0;
      int rcyc;
      int level;
      int base;
      int h;
      int hv[8];
      checks = 0;
      errors = 0;
      hv = '{7, 6, 5, 5, 4, 4, 3, 3};  // table >> 8 for C4..C5
      io.key_i   = 8'h00;
      io.beep_en = 1'b0;
      rst = 1'b1;
      #1 rst = 1'b0;
      #20;
      chk("reset_key_o", io.key_o, 8'h00);
      chk("reset_clk_div", {7'd0, io.clk_div}, 8'h00);
      chk("reset_speaker", {7'd0, io.speaker}, 8'h00);

      @(posedge clk);
      #2 rst = 1'b1;
      push_div(200);
      wait_edges(3);

      // Single press held: exactly one pulse, DB_CYCLES+2 edges later.
      c = cyc;
      io.key_i[2] = 1'b1;
      push(0, c + 6, 8'h04);
      wait_edges(20);
      io.key_i[2] = 1'b0;
      wait_edges(10);

      // Bouncing key 0 settling high, then release and press again.
      io.key_i[0] = 1'b1; wait_edges(2);
      io.key_i[0] = 1'b0; wait_edges(2);
      io.key_i[0] = 1'b1; wait_edges(2);
      io.key_i[0] = 1'b0; wait_edges(2);
      c = cyc;
      io.key_i[0] = 1'b1;
      push(0, c + 6, 8'h01);
      wait_edges(10);
      io.key_i[0] = 1'b0;
      wait_edges(10);
      c = cyc;
      io.key_i[0] = 1'b1;
      push(0, c + 6, 8'h01);
      wait_edges(10);
      io.key_i[0] = 1'b0;
      wait_edges(10);

      // Melody: eight notes, wrap to C4, then drop beep_en after relative edge 522.
      t0 = cyc;
      io.beep_en = 1'b1;
      level = 0;
      for (int n = 0; n <= 8; n++) begin
         base = 64 * n;
         h = hv[n % 8];
         for (int k = 1; k * h <= 63; k++) begin
            if (base + k * h <= 522) begin
               level = 1 - level;
               push(2, t0 + base + k * h, level[7:0]);
            end
         end
         if (base + 64 <= 522 && level == 1) begin
            push(2, t0 + base + 64, 8'h00);
            level = 0;
         end
      end
      if (level == 1) push(2, t0 + 523, 8'h00);
      wait_edges(522);
      io.beep_en = 1'b0;
      wait_edges(30);

      // Re-enable: the melody restarts at C4 (H=7).
      t1 = cyc;
      io.beep_en = 1'b1;
      push(2, t1 + 7, 8'h01);
      push(2, t1 + 14, 8'h00);
      push(2, t1 + 21, 8'h01);
      push(2, t1 + 28, 8'h00);
      wait_edges(30);
      io.beep_en = 1'b0;
      wait_edges(5);

      // Asynchronous reset with clk_div high, speaker high and key 5 mid-debounce.
      while (cyc % 10 != 2) wait_edges(1);
      r0 = cyc;
      io.beep_en = 1'b1;
      push(2, r0 + 7, 8'h01);
      push(2, r0 + 14, 8'h00);
      push(2, r0 + 21, 8'h01);
      wait_edges(20);
      io.key_i[5] = 1'b1;
      wait_edges(4);
      chk("pre_rst_clk_div", {7'd0, io.clk_div}, 8'h01);
      chk("pre_rst_speaker", {7'd0, io.speaker}, 8'h01);
      #1;
      rcyc = cyc;
      rst = 1'b0;
      io.beep_en = 1'b0;
      #1;
      chk("async_rst_key_o", io.key_o, 8'h00);
      chk("async_rst_clk_div", {7'd0, io.clk_div}, 8'h00);
      chk("async_rst_speaker", {7'd0, io.speaker}, 8'h00);
      drain(rcyc);
      #20;
      @(posedge clk);
      #2 rst = 1'b1;
      push_div(200);
      push(0, 6, 8'h20);
      wait_edges(20);
      io.key_i[5] = 1'b0;
      wait_edges(10);
      @(negedge clk);
      #1;
      drain(cyc);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
